i2c_7seg_scan: RTL

Multiplexed display scanner between the I2C slave register file and the hex-to-seven-segment decoder. Captures a packed multi-digit hex value on a valid strobe and double-buffers it so digits change only at frame boundaries. Time-multiplexes the value one nibble per digit slot onto the decoder input, with one-hot digit enables, anti-ghosting dead time and optional leading-zero blanking.

---
 rtl/i2c_7seg_scan_pkg.sv | 22 ++
 rtl/i2c_7seg_tick.sv | 32 +++
 rtl/i2c_7seg_scan.sv | 136 +++++++++++++
 3 files changed

// File: rtl/i2c_7seg_scan_pkg.sv
// i2c_7seg_pkg: shared constants and enable-polarity helper for the 7-seg scanner.
// Revision: 1.0
`default_nettype none

package i2c_7seg_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int MAX_DIGITS = 8;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  // Converts an active-high enable vector into the level driven on the pins.
  function automatic logic [MAX_DIGITS-1:0] en_to_pin(
    input logic [MAX_DIGITS-1:0] active,
    input logic                  active_low
  );
    return active_low ? ~active : active;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_7seg_tick.sv
// i2c_7seg_tick: free-running prescaler, counts 0..CLK_DIV-1 and flags the last count.
// Revision: 1.0
`default_nettype none

module i2c_7seg_tick #(
  parameter int CLK_DIV = 50000,
  parameter int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign cnt_d  = tick_o ? '0 : cnt_q + CNT_W'(1);
  assign cnt_o  = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2c_7seg_scan.sv
// i2c_7seg_scan: double-buffered multiplexed hex display scanner with dead time
// and optional leading-zero blanking. Revision: 1.0
`default_nettype none

module i2c_7seg_scan
  import i2c_7seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int CLK_DIV       = 50000,
  parameter int BLANK         = 16,
  parameter int EN_ACTIVE_LOW = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NIBBLE_W*DIGITS-1:0] data_in,
  input  logic                       data_valid,
  input  logic                       blank_lz,
  output logic [NIBBLE_W-1:0]        nibble,
  output logic [DIGITS-1:0]          digit_en,
  output logic                       frame_done
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW    = NIBBLE_W * DIGITS;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] EN_OFF   =
    DIGITS'(en_to_pin('0, (EN_ACTIVE_LOW != 0)));

  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic                tick;
  logic                boundary;

  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DW-1:0]       shadow_q, shadow_d;
  logic [DW-1:0]       disp_q, disp_d;
  logic                pending_q, pending_d;
  nibble_t             nibble_q, nibble_d;
  logic [DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                frame_done_q;

  logic [DIGITS-1:0]   lz_blank;
  logic [DIGITS-1:0]   act;
  logic                upper_zero;

  i2c_7seg_tick #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .cnt_o  (cnt),
    .tick_o (tick)
  );

  // Outputs are registered from next-state values so they move with cnt/idx.
  assign cnt_next = tick ? '0 : cnt + CNT_W'(1);
  assign boundary = tick && (idx_q == LAST_IDX);

  always_comb begin
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;

    if (tick) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end

    if (data_valid) begin
      shadow_d = data_in;
    end

    if (boundary) begin
      // A strobe on the boundary tick bypasses the shadow entirely.
      if (data_valid) begin
        disp_d    = data_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        pending_d = 1'b0;
      end
    end else if (data_valid) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    lz_blank   = '0;
    act        = '0;
    nibble_d   = '0;
    upper_zero = 1'b1;

    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero  = upper_zero && (disp_d[NIBBLE_W*i +: NIBBLE_W] == '0);
      lz_blank[i] = blank_lz && (i > 0) && upper_zero;
    end

    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nibble_d = disp_d[NIBBLE_W*i +: NIBBLE_W];
        act[i]   = (cnt_next >= CNT_W'(BLANK)) && !lz_blank[i];
      end
    end

    digit_en_d = DIGITS'(en_to_pin(MAX_DIGITS'(act), (EN_ACTIVE_LOW != 0)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q        <= '0;
      shadow_q     <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      nibble_q     <= '0;
      digit_en_q   <= EN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      nibble_q     <= nibble_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= boundary;
    end
  end

  assign nibble     = nibble_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire
